// File: rtl/sorted_reg_pq_if.sv
// Push/pop handshake bundle for sorted_reg_pq.
//   push_valid/push_ready/push_key/push_data : producer side, one entry per fire
//   pop_valid/pop_ready/pop_key/pop_data     : consumer side, head (minimum key)
// master : the environment (drives pushes, consumes pops)
// slave  : the queue itself
interface sorted_reg_pq_if #(
  parameter int KEY_W  = 8,
  parameter int DATA_W = 8
);
  logic              push_valid;
  logic              push_ready;
  logic [KEY_W-1:0]  push_key;
  logic [DATA_W-1:0] push_data;
  logic              pop_valid;
  logic              pop_ready;
  logic [KEY_W-1:0]  pop_key;
  logic [DATA_W-1:0] pop_data;

  modport master (
    output push_valid, push_key, push_data, pop_ready,
    input  push_ready, pop_valid, pop_key, pop_data
  );

  modport slave (
    input  push_valid, push_key, push_data, pop_ready,
    output push_ready, pop_valid, pop_key, pop_data
  );
endinterface

// File: rtl/sorted_reg_pq.sv
// Register-array priority queue. Holds up to DEPTH {key, data} entries kept
// sorted by ascending unsigned key; slot 0 is always the minimum and is the
// head presented on the pop side. Equal keys leave in arrival order.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears count and slots)
//   clr        : synchronous flush, empties the queue (slot contents kept)
//   bus        : push/pop valid/ready handshake bundle (slave side)
//   count      : current occupancy
//   full/empty : count == DEPTH / count == 0
// A push while full is refused even if a pop fires in the same cycle.
module sorted_reg_pq #(
  parameter int DEPTH  = 8,
  parameter int KEY_W  = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  sorted_reg_pq_if.slave     bus,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty
);

  logic [KEY_W-1:0]  slot_key_p0  [DEPTH];
  logic [DATA_W-1:0] slot_data_p0 [DEPTH];
  logic [CNT_W-1:0]  count_p0;

  logic [KEY_W-1:0]  key_nxt  [DEPTH];
  logic [DATA_W-1:0] data_nxt [DEPTH];

  // Slot array extended by one zero entry so "slot above" is always in range.
  logic [KEY_W-1:0]  ext_key  [DEPTH+1];
  logic [DATA_W-1:0] ext_data [DEPTH+1];
  // Slot array shifted by one, zero below slot 0.
  logic [KEY_W-1:0]  lo_key   [DEPTH];
  logic [DATA_W-1:0] lo_data  [DEPTH];

  // stay_push[j]: valid slot j has key <= push_key (entry stays ahead of push)
  // stay_rem[j] : same test over the remaining entries after the head leaves
  logic [DEPTH-1:0]  stay_push;
  logic [DEPTH-1:0]  stay_rem;
  logic [DEPTH-1:0]  stay;
  logic [DEPTH-1:0]  stay_prev;

  logic push_fire;
  logic pop_fire;

  function automatic logic [CNT_W-1:0] next_count(
    input logic [CNT_W-1:0] cur,
    input logic             push,
    input logic             pop
  );
    logic [CNT_W-1:0] res;
    res = cur;
    if (push && !pop) res = cur + CNT_W'(1);
    if (pop && !push) res = cur - CNT_W'(1);
    return res;
  endfunction

  assign full  = (count_p0 == CNT_W'(DEPTH));
  assign empty = (count_p0 == '0);
  assign count = count_p0;

  assign bus.push_ready = !full;
  assign bus.pop_valid  = !empty;
  assign bus.pop_key    = empty ? '0 : slot_key_p0[0];
  assign bus.pop_data   = empty ? '0 : slot_data_p0[0];

  assign push_fire = bus.push_valid && !full;
  assign pop_fire  = bus.pop_ready && !empty;

  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      ext_key[j]  = slot_key_p0[j];
      ext_data[j] = slot_data_p0[j];
    end
    ext_key[DEPTH]  = '0;
    ext_data[DEPTH] = '0;

    lo_key[0]  = '0;
    lo_data[0] = '0;
    for (int j = 1; j < DEPTH; j++) begin
      lo_key[j]  = slot_key_p0[j-1];
      lo_data[j] = slot_data_p0[j-1];
    end

    for (int j = 0; j < DEPTH; j++) begin
      stay_push[j] = (CNT_W'(j) < count_p0) && (ext_key[j] <= bus.push_key);
      stay_rem[j]  = (CNT_W'(j + 1) < count_p0) && (ext_key[j+1] <= bus.push_key);
    end
  end

  // The stay flags form a prefix (array is sorted), so the insertion slot is
  // the first j whose flag is clear while every slot below it stays.
  assign stay      = pop_fire ? stay_rem : stay_push;
  assign stay_prev = {stay[DEPTH-2:0], 1'b1};

  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      key_nxt[j]  = pop_fire ? ext_key[j+1]  : ext_key[j];
      data_nxt[j] = pop_fire ? ext_data[j+1] : ext_data[j];
      if (push_fire && !stay[j]) begin
        if (stay_prev[j]) begin
          key_nxt[j]  = bus.push_key;
          data_nxt[j] = bus.push_data;
        end else begin
          // Entries behind the insertion point move up one relative to
          // their post-pop position.
          key_nxt[j]  = pop_fire ? ext_key[j]  : lo_key[j];
          data_nxt[j] = pop_fire ? ext_data[j] : lo_data[j];
        end
      end
    end
  end

  // ---- stage p0: slot array and occupancy ----
  always_ff @(posedge clk) begin
    if (rst) begin
      count_p0 <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        slot_key_p0[j]  <= '0;
        slot_data_p0[j] <= '0;
      end
    end else if (clr) begin
      count_p0 <= '0;
    end else begin
      count_p0 <= next_count(count_p0, push_fire, pop_fire);
      for (int j = 0; j < DEPTH; j++) begin
        slot_key_p0[j]  <= key_nxt[j];
        slot_data_p0[j] <= data_nxt[j];
      end
    end
  end

endmodule

// File: tb/tb_sorted_reg_pq.sv
module tb_sorted_reg_pq;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             clr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;

  sorted_reg_pq_if #(.KEY_W(8), .DATA_W(8)) bus ();

  sorted_reg_pq #(.DEPTH(DEPTH), .KEY_W(8), .DATA_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .bus   (bus),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  logic [15:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  // Monitor: every cycle the consumer is ready, compare against the scoreboard.
  always @(negedge clk) begin
    if (!rst && !clr && bus.pop_ready) begin
      if (exp_q.size() > 0) begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("pop_valid", 32'(bus.pop_valid), 32'd1);
        chk("pop_key",   32'(bus.pop_key),   32'(e[15:8]));
        chk("pop_data",  32'(bus.pop_data),  32'(e[7:0]));
      end else if (bus.pop_valid) begin
        chk("unexpected_pop_valid", 32'(bus.pop_valid), 32'd0);
      end
    end
  end

  task automatic cyc(input logic pv, input logic [7:0] k, input logic [7:0] d, input logic pr);
    bus.push_valid = pv;
    bus.push_key   = k;
    bus.push_data  = d;
    bus.pop_ready  = pr;
    @(posedge clk);
    #1;
    bus.push_valid = 1'b0;
    bus.pop_ready  = 1'b0;
  endtask

  task automatic push(input logic [7:0] k, input logic [7:0] d);
    cyc(1'b1, k, d, 1'b0);
  endtask

  task automatic pop_exp(input logic [7:0] k, input logic [7:0] d);
    exp_q.push_back({k, d});
    cyc(1'b0, 8'h00, 8'h00, 1'b1);
  endtask

  task automatic pushpop(input logic [7:0] pk, input logic [7:0] pd,
                         input logic [7:0] ek, input logic [7:0] ed);
    exp_q.push_back({ek, ed});
    cyc(1'b1, pk, pd, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    bus.push_valid = 1'b0;
    bus.push_key   = '0;
    bus.push_data  = '0;
    bus.pop_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_pop_valid",  32'(bus.pop_valid),  32'd0);
    chk("rst_count",      32'(count),          32'd0);
    chk("rst_empty",      32'(empty),          32'd1);
    chk("rst_full",       32'(full),           32'd0);
    chk("rst_push_ready", 32'(bus.push_ready), 32'd1);
    chk("rst_pop_key",    32'(bus.pop_key),    32'h00);
    chk("rst_pop_data",   32'(bus.pop_data),   32'h00);

    // Ordering
    push(8'h40, 8'hBF);
    chk("first_push_visible", 32'(bus.pop_key), 32'h40);
    push(8'h10, 8'hEF);
    push(8'h30, 8'hCF);
    push(8'h20, 8'hDF);
    chk("ord_count4", 32'(count), 32'd4);
    pop_exp(8'h10, 8'hEF);
    chk("ord_count3", 32'(count), 32'd3);
    pop_exp(8'h20, 8'hDF);
    chk("ord_count2", 32'(count), 32'd2);
    pop_exp(8'h30, 8'hCF);
    chk("ord_count1", 32'(count), 32'd1);
    pop_exp(8'h40, 8'hBF);
    chk("ord_count0", 32'(count), 32'd0);
    chk("ord_empty",  32'(empty), 32'd1);

    // Pop while empty is ignored
    cyc(1'b0, 8'h00, 8'h00, 1'b1);
    chk("empty_pop_count", 32'(count), 32'd0);

    // Equal keys leave in arrival order
    push(8'h05, 8'hA1);
    push(8'h05, 8'hA2);
    push(8'h05, 8'hA3);
    pop_exp(8'h05, 8'hA1);
    pop_exp(8'h05, 8'hA2);
    pop_exp(8'h05, 8'hA3);

    // Full boundary
    for (int i = 1; i <= 8; i++) push(8'(i * 16), 8'(i * 16 + 1));
    chk("full_flag",       32'(full),           32'd1);
    chk("full_push_ready", 32'(bus.push_ready), 32'd0);
    chk("full_count",      32'(count),          32'd8);
    push(8'h00, 8'h55);
    chk("full_ignored_count", 32'(count),       32'd8);
    chk("full_ignored_head",  32'(bus.pop_key), 32'h10);
    // Pop fires, push refused because full was set at the start of the cycle
    pushpop(8'h00, 8'h55, 8'h10, 8'h11);
    chk("full_pp_count", 32'(count),       32'd7);
    chk("full_pp_head",  32'(bus.pop_key), 32'h20);
    push(8'h00, 8'h55);
    chk("refill_head_key",  32'(bus.pop_key),  32'h00);
    chk("refill_head_data", 32'(bus.pop_data), 32'h55);
    chk("refill_count",     32'(count),        32'd8);
    pop_exp(8'h00, 8'h55);
    for (int i = 2; i <= 8; i++) pop_exp(8'(i * 16), 8'(i * 16 + 1));
    chk("drain_empty", 32'(empty), 32'd1);

    // Simultaneous push and pop
    push(8'h10, 8'h01);
    push(8'h20, 8'h02);
    pushpop(8'h15, 8'h03, 8'h10, 8'h01);
    chk("pp1_head",  32'(bus.pop_key), 32'h15);
    chk("pp1_count", 32'(count),       32'd2);
    pushpop(8'h25, 8'h04, 8'h15, 8'h03);
    chk("pp2_head",  32'(bus.pop_key), 32'h20);
    chk("pp2_count", 32'(count),       32'd2);
    pushpop(8'h05, 8'h05, 8'h20, 8'h02);
    chk("pp3_head",  32'(bus.pop_key),  32'h05);
    chk("pp3_data",  32'(bus.pop_data), 32'h05);
    chk("pp3_count", 32'(count),        32'd2);

    // clr with a concurrent push
    push(8'h30, 8'h06);
    chk("pre_clr_count", 32'(count), 32'd3);
    clr = 1'b1;
    push(8'h01, 8'h07);
    clr = 1'b0;
    chk("clr_count",     32'(count),         32'd0);
    chk("clr_pop_valid", 32'(bus.pop_valid), 32'd0);
    chk("clr_pop_key",   32'(bus.pop_key),   32'h00);
    chk("clr_pop_data",  32'(bus.pop_data),  32'h00);
    push(8'h77, 8'h88);
    pop_exp(8'h77, 8'h88);

    // Reset mid-stream with a concurrent push
    push(8'h11, 8'h22);
    push(8'h12, 8'h23);
    rst = 1'b1;
    push(8'h01, 8'h02);
    rst = 1'b0;
    chk("rst2_count",   32'(count),       32'd0);
    chk("rst2_empty",   32'(empty),       32'd1);
    chk("rst2_pop_key", 32'(bus.pop_key), 32'h00);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
